padd_result_streamer: RTL and testbench

Downstream capture-and-readout stage for the PADD18 pre-adder chain test designs. After a start pulse it waits a programmable settle time, snapshots all chain result words in one cycle, then streams them out as a framed, checksummed byte stream over a valid/ready handshake. The firmware-side UART/bus bridge consumes the stream, so chain results are read from one coherent cycle rather than word by word.

---
 rtl/padd_result_streamer.sv | 115 +++++++++++
 tb/tb_padd_result_streamer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/padd_result_streamer.sv
// Capture-and-readout stage: after a start pulse and settle delay, snapshots all
// result words in one cycle and streams them as a framed, XOR-checksummed byte stream.
module padd_result_streamer #(
    parameter int unsigned NUM_WORDS     = 5,
    parameter int unsigned WORD_W        = 64,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [7:0]  HDR_BYTE      = 8'hA5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_WORDS*WORD_W-1:0] prod_in,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned      NBYTES    = NUM_WORDS * WORD_W / 8;
    localparam int unsigned      IDX_W     = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SNAP, S_HDR, S_DATA, S_CSUM
    } state_t;

    state_t                        r_state, w_state_nxt;
    logic [7:0]                    r_cnt;
    logic [IDX_W-1:0]              r_idx, w_idx_nxt;
    logic [7:0]                    r_csum, w_csum_nxt;
    logic [NUM_WORDS*WORD_W-1:0]   r_snap;
    logic [7:0]                    r_tx_data, w_tx_data_nxt;
    logic                          r_tx_valid, w_tx_valid_nxt;
    logic                          r_busy;
    logic                          r_done;
    logic                          w_accept;

    assign w_accept = r_tx_valid & tx_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A start arriving in the done cycle is dropped: r_done marks that cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start && !r_done)
                          w_state_nxt = (SETTLE_CYCLES == 0) ? S_SNAP : S_SETTLE;
            S_SETTLE: if (r_cnt <= 8'd1) w_state_nxt = S_SNAP;
            S_SNAP:   w_state_nxt = S_HDR;
            S_HDR:    if (w_accept) w_state_nxt = S_DATA;
            S_DATA:   if (w_accept && (r_idx == LAST_IDX)) w_state_nxt = S_CSUM;
            S_CSUM:   if (w_accept) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so tx_data/tx_valid can be registered
    // without adding a bubble between header, data and checksum bytes.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_csum_nxt = r_csum;
        if (r_state == S_SNAP) begin
            w_idx_nxt  = '0;
            w_csum_nxt = 8'h00;
        end else if ((r_state == S_DATA) && w_accept) begin
            w_idx_nxt  = r_idx + 1'b1;
            w_csum_nxt = r_csum ^ r_tx_data;
        end

        w_tx_valid_nxt = (w_state_nxt inside {S_HDR, S_DATA, S_CSUM});
        case (w_state_nxt)
            S_HDR:   w_tx_data_nxt = HDR_BYTE;
            S_DATA:  w_tx_data_nxt = 8'(r_snap >> {w_idx_nxt, 3'b000});
            S_CSUM:  w_tx_data_nxt = w_csum_nxt;
            default: w_tx_data_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 8'h00;
            r_idx      <= '0;
            r_csum     <= 8'h00;
            r_snap     <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && (w_state_nxt == S_SETTLE))
                r_cnt <= SETTLE_LD;
            else if (r_state == S_SETTLE)
                r_cnt <= r_cnt - 8'd1;
            if (r_state == S_SNAP)
                r_snap <= prod_in;
            r_idx      <= w_idx_nxt;
            r_csum     <= w_csum_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (r_state == S_CSUM) && w_accept;
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_padd_result_streamer.sv
// Bench for padd_result_streamer: directed frames plus randomized data/backpressure,
// checked against a byte-stream model of the frame format.
module tb_padd_result_streamer;
    localparam int NW   = 5;
    localparam int WW   = 64;
    localparam int ST   = 8;
    localparam int NB   = NW * WW / 8;
    localparam int FLEN = NB + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [NW*WW-1:0] prod_in;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;

    logic             start1;
    logic [63:0]      prod1;
    logic [7:0]       data1;
    logic             valid1;
    logic             ready1;
    logic             busy1;
    logic             done1;

    int               ncmp = 0;
    int               nfail = 0;
    logic [7:0]       got_q[$];
    logic [7:0]       exp_q[$];
    logic [7:0]       ref_q[$];
    logic [7:0]       q1[$];
    int               first_rel;
    int               done_rel;
    logic [NW*WW-1:0] snap_val;
    logic [7:0]       exp1 [10] = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89,
                                    8'h67, 8'h45, 8'h23, 8'h01, 8'h00};

    padd_result_streamer dut (
        .clk(clk), .reset(reset), .start(start), .prod_in(prod_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    padd_result_streamer #(.NUM_WORDS(1), .WORD_W(64), .SETTLE_CYCLES(0), .HDR_BYTE(8'hA5)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .prod_in(prod1),
        .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [NW*WW-1:0] rand_vec();
        logic [NW*WW-1:0] v;
        for (int i = 0; i < NW * WW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Frame = header, then the whole flattened vector as a little-endian byte string
    // (word 0 first, LSB byte first), then the XOR of those data bytes.
    function automatic void build_exp(input logic [NW*WW-1:0] p);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NB; i++) begin
            b = 8'(p >> (8 * i));
            exp_q.push_back(b);
            x = x ^ b;
        end
        exp_q.push_back(x);
    endfunction

    // Called at the sample point one cycle after the start edge (relative cycle 1).
    task automatic collect(input int mode, input bit pulses, input bit coh);
        int         rel;
        bit         prev_stall;
        bit         fin;
        logic [7:0] prev_data;
        rel = 1; prev_stall = 0; fin = 0; prev_data = 8'h00;
        got_q.delete();
        first_rel = -1;
        done_rel  = -1;
        snap_val  = prod_in;
        while (!fin && rel < 3000) begin
            if (coh) begin
                prod_in = rand_vec();
                if (rel == ST + 1) snap_val = prod_in;
            end
            start = pulses && (rel == 3 || rel == 20);
            if (prev_stall) begin
                chk("stall_valid", 64'(tx_valid), 64'd1);
                chk("stall_data", 64'(tx_data), 64'(prev_data));
            end
            chk("no_early_done", 64'(done), 64'd0);
            if (tx_valid && first_rel < 0) first_rel = rel;
            tx_ready   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            step();
            rel++;
            if (got_q.size() == FLEN) begin
                fin = 1;
                done_rel = rel;
                chk("done_pulse", 64'(done), 64'd1);
                chk("busy_low_at_done", 64'(busy), 64'd0);
            end
        end
        start = 1'b0;
        if (!fin) chk("frame_timeout", 64'(got_q.size()), 64'(FLEN));
    endtask

    task automatic check_frame(input string name, input bit timed);
        build_exp(snap_val);
        chk({name, "_len"}, 64'(got_q.size()), 64'(FLEN));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        if (timed) begin
            chk({name, "_hdr_time"}, 64'(first_rel), 64'(ST + 2));
            chk({name, "_done_time"}, 64'(done_rel), 64'(ST + 2 + FLEN));
        end
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    initial begin
        int n;
        int rel;
        reset = 1'b1; start = 1'b0; tx_ready = 1'b0; prod_in = '0;
        start1 = 1'b0; ready1 = 1'b0; prod1 = '0;
        step(); step(); step();
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid1", 64'(valid1), 64'd0);
        reset = 1'b0;
        step();

        // Directed frame: word0 = 0x0F18, everything else zero.
        prod_in = '0;
        prod_in[63:0] = 64'h0F18;
        kick();
        collect(0, 0, 0);
        check_frame("basic", 1);
        chk("basic_hdr", 64'(got_q[0]), 64'hA5);
        chk("basic_b1", 64'(got_q[1]), 64'h18);
        chk("basic_b2", 64'(got_q[2]), 64'h0F);
        chk("basic_csum", 64'(got_q[FLEN-1]), 64'h17);
        ref_q = got_q;

        // Same data under random backpressure.
        step();
        kick();
        collect(1, 0, 0);
        check_frame("stall", 0);
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            chk($sformatf("stall_vs_nostall%0d", i), 64'(got_q[i]), 64'(ref_q[i]));

        // prod_in changes every cycle; only the SNAP-cycle value may appear.
        step();
        kick();
        collect(0, 0, 1);
        check_frame("coherent", 1);

        // start pulses in SETTLE, DATA and the done cycle are ignored.
        step();
        prod_in = rand_vec();
        kick();
        collect(0, 1, 0);
        check_frame("ignore", 1);
        start = 1'b1;
        step();
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        prod_in = rand_vec();
        step();
        start = 1'b0;
        chk("restart_busy", 64'(busy), 64'd1);
        collect(0, 0, 0);
        check_frame("restart", 1);

        // Reset in the middle of DATA while stalled.
        step();
        prod_in = rand_vec();
        kick();
        tx_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n < 6; c++) begin
            if (tx_valid && tx_ready) n++;
            step();
        end
        chk("reached_data", 64'(n), 64'd6);
        tx_ready = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_valid", 64'(tx_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_data", 64'(tx_data), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("abort_no_done", 64'(done), 64'd0);
            chk("abort_idle_valid", 64'(tx_valid), 64'd0);
        end
        prod_in = rand_vec();
        kick();
        collect(0, 0, 0);
        check_frame("after_reset", 1);

        // Single word, no settle delay.
        step();
        prod1  = 64'h0123456789ABCDEF;
        ready1 = 1'b1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        rel = 1;
        first_rel = -1;
        q1.delete();
        while (q1.size() < 10 && rel < 50) begin
            if (valid1 && first_rel < 0) first_rel = rel;
            if (valid1 && ready1) q1.push_back(data1);
            step();
            rel++;
        end
        chk("s0_len", 64'(q1.size()), 64'd10);
        chk("s0_hdr_time", 64'(first_rel), 64'd2);
        for (int i = 0; i < q1.size() && i < 10; i++)
            chk($sformatf("s0_byte%0d", i), 64'(q1[i]), 64'(exp1[i]));
        chk("s0_done", 64'(done1), 64'd1);
        chk("s0_done_time", 64'(rel), 64'd12);
        chk("s0_busy_low", 64'(busy1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
